// File: rtl/nmi_arb_pkg.sv
// Shared types and constants for the two-master NMI arbiter.
package nmi_arb_pkg;

    // The state encoding doubles as the owner_o encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_CPU = 2'b01,
        GNT_DMA = 2'b10
    } arb_state_e;

    localparam logic [1:0]  OWNER_NONE = 2'b00;
    localparam logic [1:0]  OWNER_CPU  = 2'b01;
    localparam logic [1:0]  OWNER_DMA  = 2'b10;

    // Read data returned to a master whose transfer was killed by the watchdog.
    localparam logic [31:0] TMO_RDATA  = 32'hDEAD_BEEF;

    function automatic logic [1:0] state_owner(arb_state_e s);
        logic [1:0] own;
        case (s)
            GNT_CPU: own = OWNER_CPU;
            GNT_DMA: own = OWNER_DMA;
            default: own = OWNER_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/nmi_arb_tmo.sv
// Watchdog for a granted NMI transfer: counts cycles spent waiting for
// downstream ready and raises a one-cycle fire pulse plus a sticky flag.
// Only instantiated when NMI_ARB_TIMEOUT_EN is defined.
module nmi_arb_tmo
    import nmi_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_active,
    input  logic i_ready,
    input  logic i_clr,
    output logic o_fire,
    output logic o_irq
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_irq;
    logic          w_fire;

    assign w_fire = i_active & ~i_ready & (r_cnt == CNT_LAST);
    assign o_fire = w_fire;
    assign o_irq  = r_irq;

    // Wait counter: held at zero outside a live grant so every grant starts fresh.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (!i_active || i_ready || w_fire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky flag: a new timeout beats a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
        end else if (w_fire) begin
            r_irq <= 1'b1;
        end else if (i_clr) begin
            r_irq <= 1'b0;
        end
    end

endmodule

// File: rtl/nmi_master_arb.sv
// Two-master (CPU/DMA) arbiter onto a single NMI bus. Grants are registered,
// held for one valid->ready transfer, ties go round-robin, and one idle
// cycle separates transfers. Optional watchdog: define NMI_ARB_TIMEOUT_EN.
module nmi_master_arb
    import nmi_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_cpu_valid,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    input  logic [3:0]  i_cpu_wstrb,
    output logic        o_cpu_ready,
    output logic [31:0] o_cpu_rdata,
    input  logic        i_dma_valid,
    input  logic [31:0] i_dma_addr,
    input  logic [31:0] i_dma_wdata,
    input  logic [3:0]  i_dma_wstrb,
    output logic        o_dma_ready,
    output logic [31:0] o_dma_rdata,
    output logic        o_nmi_valid,
    output logic [31:0] o_nmi_addr,
    output logic [31:0] o_nmi_wdata,
    output logic [3:0]  o_nmi_wstrb,
    input  logic        i_nmi_ready,
    input  logic [31:0] i_nmi_rdata,
    output logic [1:0]  owner_o,
    output logic        tmo_irq_o,
    input  logic        tmo_clr_i
);

    arb_state_e  r_state;
    logic        r_last_dma;

    logic        w_gnt_cpu;
    logic        w_gnt_dma;
    logic        w_req;
    logic        w_done;
    logic        w_tmo_fire;
    logic [31:0] w_rsp_rdata;

    assign w_gnt_cpu = (r_state == GNT_CPU);
    assign w_gnt_dma = (r_state == GNT_DMA);

    // A grant is live only while its owner keeps valid high; dropping it abandons the grant.
    assign w_req  = (w_gnt_cpu & i_cpu_valid) | (w_gnt_dma & i_dma_valid);
    assign w_done = w_req & i_nmi_ready;

`ifdef NMI_ARB_TIMEOUT_EN
    nmi_arb_tmo #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_active (w_req),
        .i_ready  (i_nmi_ready),
        .i_clr    (tmo_clr_i),
        .o_fire   (w_tmo_fire),
        .o_irq    (tmo_irq_o)
    );
`else
    logic w_unused_tmo;
    assign w_unused_tmo = tmo_clr_i ^ (TIMEOUT_CYCLES < 2);
    assign w_tmo_fire   = 1'b0;
    assign tmo_irq_o    = 1'b0;
`endif

    // Response data is zero except in the completing cycle.
    assign w_rsp_rdata = w_done     ? i_nmi_rdata :
                         w_tmo_fire ? TMO_RDATA   : 32'h0;

    assign o_cpu_ready = w_gnt_cpu & (w_done | w_tmo_fire);
    assign o_dma_ready = w_gnt_dma & (w_done | w_tmo_fire);
    assign o_cpu_rdata = w_gnt_cpu ? w_rsp_rdata : 32'h0;
    assign o_dma_rdata = w_gnt_dma ? w_rsp_rdata : 32'h0;

    assign owner_o = state_owner(r_state);

    // Downstream mux: owner's request fields, all zero while idle.
    always_comb begin
        o_nmi_valid = w_req & ~w_tmo_fire;
        o_nmi_addr  = 32'h0;
        o_nmi_wdata = 32'h0;
        o_nmi_wstrb = 4'h0;
        if (w_gnt_cpu) begin
            o_nmi_addr  = i_cpu_addr;
            o_nmi_wdata = i_cpu_wdata;
            o_nmi_wstrb = i_cpu_wstrb;
        end else if (w_gnt_dma) begin
            o_nmi_addr  = i_dma_addr;
            o_nmi_wdata = i_dma_wdata;
            o_nmi_wstrb = i_dma_wstrb;
        end
    end

    // Grant FSM; last owner starts as DMA so the CPU wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_last_dma <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cpu_valid && i_dma_valid) begin
                        r_state <= r_last_dma ? GNT_CPU : GNT_DMA;
                    end else if (i_cpu_valid) begin
                        r_state <= GNT_CPU;
                    end else if (i_dma_valid) begin
                        r_state <= GNT_DMA;
                    end
                end
                GNT_CPU, GNT_DMA: begin
                    if (w_done || w_tmo_fire) begin
                        r_state    <= IDLE;
                        r_last_dma <= w_gnt_dma;
                    end else if (!w_req) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
